// File: rtl/poly_interp_6x.sv
// poly_interp_6x
//
// Polyphase interpolating FIR for the synthesis (inverse DWT) path. Each accepted
// low-rate sample produces PHASES high-rate output samples, one per clock. Phase p is
// the TAPS-tap dot product of coefficient row p with a shared input delay line. The
// coefficients live in a runtime-writable register bank.
//
// Ports
//   clk         clock
//   rstn        asynchronous active-low reset (clears delay line, coefficients, FSM, outputs)
//   flush       synchronous clear of the delay line and any burst in progress; coefficients kept
//   in_valid    input sample valid
//   in_ready    a sample can be accepted this cycle
//   in_data     signed low-rate sample (W_IN bits)
//   coef_we     coefficient write strobe
//   coef_addr   coefficient index = phase*TAPS + tap; indices >= PHASES*TAPS are ignored
//   coef_wdata  signed coefficient (C_IN bits)
//   out_valid   out_data holds a freshly computed phase
//   out_phase   phase index of out_data (0..PHASES-1)
//   out_data    signed interpolated sample (Y_OUT bits)
//
// Timing: a sample accepted at edge t makes phase p visible after edge t+1+p. With
// in_valid held high the next sample is taken on the last-phase cycle, so output is
// continuous.

module poly_interp_6x #(
    parameter int unsigned W_IN   = 7,
    parameter int unsigned C_IN   = 5,
    parameter int unsigned Y_OUT  = 20,
    parameter int unsigned PHASES = 6,
    parameter int unsigned TAPS   = 4,
    parameter int unsigned A_W    = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_IN-1:0]  in_data,
    input  logic             coef_we,
    input  logic [A_W-1:0]   coef_addr,
    input  logic [C_IN-1:0]  coef_wdata,
    output logic             out_valid,
    output logic [2:0]       out_phase,
    output logic [Y_OUT-1:0] out_data
);

    localparam int unsigned NCOEF = PHASES * TAPS;
    // Full-precision product width.
    localparam int unsigned P_W = W_IN + C_IN;
    localparam logic [2:0]  LAST_PHASE = 3'(PHASES - 1);
    localparam logic [A_W:0] NCOEF_LIM = (A_W + 1)'(NCOEF);

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    state_e          state_q;
    logic [2:0]      phase_q;
    logic [W_IN-1:0] d_q    [TAPS];
    logic [C_IN-1:0] coef_q [NCOEF];

    logic                  accept;
    logic                  compute;
    logic                  coef_hit;
    logic [A_W-1:0]        cidx [TAPS];
    logic signed [P_W-1:0] prod [TAPS];
    logic [Y_OUT-1:0]      y_sum;

    // Ready in IDLE, or on the last phase of a burst so the next burst follows with
    // no bubble. A flush cycle never accepts.
    always_comb begin
        in_ready = !flush && ((state_q == StIdle) || (phase_q == LAST_PHASE));
        accept   = in_valid && in_ready;
        compute  = (state_q == StRun) && !flush;
        coef_hit = coef_we && ({1'b0, coef_addr} < NCOEF_LIM);
    end

    // Dot product for the current phase. The accumulator is Y_OUT bits wide. The sign
    // extension of each product, together with modulo-2^Y_OUT addition, gives the exact
    // sum when it fits. When the sum is wider than Y_OUT it gives the two's-complement
    // wrap, that is, the low Y_OUT bits.
    always_comb begin
        y_sum = '0;
        for (int k = 0; k < TAPS; k++) begin
            cidx[k] = A_W'(32'(phase_q) * TAPS + 32'(k));
            prod[k] = P_W'($signed(coef_q[cidx[k]])) * P_W'($signed(d_q[k]));
            y_sum   = y_sum + Y_OUT'(prod[k]);
        end
    end

    // Coefficient bank. A write takes effect after the edge, so a computation in the
    // same cycle still sees the old value. Writes are allowed in any state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NCOEF; i++) begin
                coef_q[i] <= '0;
            end
        end else if (coef_hit) begin
            coef_q[coef_addr] <= coef_wdata;
        end
    end

    // Delay line, burst FSM and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < TAPS; k++) begin
                d_q[k] <= '0;
            end
            state_q   <= StIdle;
            phase_q   <= '0;
            out_valid <= 1'b0;
            out_phase <= '0;
            out_data  <= '0;
        end else if (flush) begin
            for (int k = 0; k < TAPS; k++) begin
                d_q[k] <= '0;
            end
            state_q   <= StIdle;
            phase_q   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                d_q[0] <= in_data;
                for (int k = 1; k < TAPS; k++) begin
                    d_q[k] <= d_q[k-1];
                end
            end

            unique case (state_q)
                StIdle: begin
                    out_valid <= 1'b0;
                    if (accept) begin
                        state_q <= StRun;
                        phase_q <= '0;
                    end
                end
                StRun: begin
                    // The last phase reads the pre-shift delay line, because d_q
                    // updates on this same edge.
                    out_data  <= y_sum;
                    out_phase <= phase_q;
                    out_valid <= compute;
                    if (phase_q == LAST_PHASE) begin
                        phase_q <= '0;
                        if (!accept) begin
                            state_q <= StIdle;
                        end
                    end else begin
                        phase_q <= phase_q + 3'd1;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    phase_q   <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly_interp_6x.sv
// Testbench for poly_interp_6x.
// The reference model works at the transaction level. Each accepted sample queues
// PHASES pending outputs, and each pending output carries a snapshot of the delay line.
// One output is retired per clock. Its value is the sum of the coefficient row times the
// snapshot, using the coefficients as they stand at that edge. in_ready is expected
// when at most one output is still pending and no flush is asserted.

module tb_poly_interp_6x;

    localparam int NPH   = 6;
    localparam int NTAP  = 4;
    localparam int NCOEF = NPH * NTAP;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_data;
    logic        coef_we;
    logic [4:0]  coef_addr;
    logic [4:0]  coef_wdata;
    logic        out_valid;
    logic [2:0]  out_phase;
    logic [19:0] out_data;

    poly_interp_6x dut (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .out_valid  (out_valid),
        .out_phase  (out_phase),
        .out_data   (out_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    int          m_coef [NCOEF];
    int          m_d    [NTAP];
    int          ph_q   [$];
    int          snap_q [$];
    logic        exp_valid;
    logic [2:0]  exp_phase;
    logic [19:0] exp_data;
    logic        last_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCOEF; i++) m_coef[i] = 0;
        for (int k = 0; k < NTAP; k++) m_d[k] = 0;
        ph_q.delete();
        snap_q.delete();
        exp_valid = 1'b0;
        exp_phase = '0;
        exp_data  = '0;
        last_acc  = 1'b0;
    endtask

    // One clock: check in_ready before the edge, advance the model at the edge, and
    // check the registered outputs just after it.
    task automatic cycle();
        logic exp_ready;
        int   sum;
        int   ph;
        @(negedge clk);
        exp_ready = !flush && (ph_q.size() <= 1);
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        last_acc = in_valid && exp_ready;
        @(posedge clk);
        if (flush) begin
            ph_q.delete();
            snap_q.delete();
            for (int k = 0; k < NTAP; k++) m_d[k] = 0;
            exp_valid = 1'b0;
        end else begin
            if (ph_q.size() > 0) begin
                ph  = ph_q.pop_front();
                sum = 0;
                for (int k = 0; k < NTAP; k++) sum += m_coef[ph*NTAP + k] * snap_q.pop_front();
                exp_valid = 1'b1;
                exp_phase = 3'(ph);
                exp_data  = 20'(sum);
            end else begin
                exp_valid = 1'b0;
            end
            if (last_acc) begin
                for (int k = NTAP - 1; k > 0; k--) m_d[k] = m_d[k-1];
                m_d[0] = int'($signed(in_data));
                for (int p = 0; p < NPH; p++) begin
                    ph_q.push_back(p);
                    for (int k = 0; k < NTAP; k++) snap_q.push_back(m_d[k]);
                end
            end
        end
        if (coef_we && coef_addr < 5'd24) m_coef[coef_addr] = int'($signed(coef_wdata));
        #1;
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        check("out_phase", 32'(out_phase), 32'(exp_phase));
        check("out_data", 32'(out_data), 32'(exp_data));
    endtask

    task automatic send(input int x, input bit keep);
        in_valid = 1'b1;
        in_data  = 7'(x);
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (last_acc) break;
        end
        check("accept_timeout", 32'(last_acc), 32'd1);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && ph_q.size() > 0; i++) cycle();
        cycle();
        check("drain_empty", 32'(ph_q.size()), 32'd0);
    endtask

    task automatic wr_coef(input int a, input int v);
        coef_we    = 1'b1;
        coef_addr  = 5'(a);
        coef_wdata = 5'(v);
        cycle();
        coef_we = 1'b0;
    endtask

    task automatic run_until_pending(input int n);
        for (int i = 0; i < 12 && ph_q.size() != n; i++) cycle();
        check("pending_reach", 32'(ph_q.size()), 32'(n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rstn       = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_phase", 32'(out_phase), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        rstn = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Single burst: c[p*4+0] = p-2, x=5 gives -10,-5,0,5,10,15.
        for (int p = 0; p < NPH; p++) wr_coef(p*NTAP, p - 2);
        send(5, 1'b0);
        drain();

        // Out-of-range writes must leave the bank untouched.
        for (int a = 24; a < 32; a++) wr_coef(a, 7);
        send(5, 1'b0);
        drain();

        // Flush on phase 2, with tap 2 also live so a stale delay line would show.
        for (int p = 0; p < NPH; p++) wr_coef(p*NTAP + 2, 1);
        send(7, 1'b0);
        drain();
        send(5, 1'b0);
        run_until_pending(4);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        send(0, 1'b0);
        drain();
        send(5, 1'b0);
        drain();

        // Back-to-back: tap 1 only, x = 1,2,3 with in_valid held high.
        for (int a = 0; a < NCOEF; a++) wr_coef(a, (a % NTAP == 1) ? 1 : 0);
        send(1, 1'b1);
        send(2, 1'b1);
        send(3, 1'b0);
        drain();

        // Extremes: all coefficients -16, four samples of -64 and then four of 63.
        for (int a = 0; a < NCOEF; a++) wr_coef(a, -16);
        for (int i = 0; i < 4; i++) send(-64, i < 3);
        drain();
        for (int i = 0; i < 4; i++) send(63, i < 3);
        drain();

        // Asynchronous reset in phase 3 of a burst.
        send(5, 1'b0);
        run_until_pending(3);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_phase", 32'(out_phase), 32'd0);
        check("arst_out_data", 32'(out_data), 32'd0);
        model_reset();
        rstn = 1'b1;
        send(5, 1'b0);
        drain();

        // Random traffic with writes and flushes interleaved.
        for (int a = 0; a < NCOEF; a++) wr_coef(a, int'($urandom_range(0, 31)));
        in_valid = 1'b0;
        last_acc = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!(in_valid && !last_acc)) begin
                in_valid = ($urandom % 3) != 0;
                in_data  = 7'($urandom);
            end
            coef_we    = ($urandom % 6) == 0;
            coef_addr  = 5'($urandom);
            coef_wdata = 5'($urandom);
            flush      = ($urandom % 30) == 0;
            cycle();
        end
        in_valid = 1'b0;
        coef_we  = 1'b0;
        flush    = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/poly_interp_6x.md
Name: poly_interp_6x

Overview:
Polyphase interpolating FIR for the synthesis (inverse DWT) path. It is the counterpart of the 6-phase decimating analysis branches, which consume several samples and produce one. This block consumes one low-rate subband sample and emits PHASES high-rate output samples, one per clock. Each phase is a TAPS-tap MAC over a shared input delay line, using a runtime-loadable coefficient bank.

Parameters:
W_IN, 7, signed input sample width
C_IN, 5, signed coefficient width
Y_OUT, 20, signed output width
PHASES, 6, output samples per input sample (interpolation factor)
TAPS, 4, taps per phase
A_W, 5, coefficient address width; must satisfy 2^A_W >= PHASES*TAPS

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
flush  in  1  synchronous clear of delay line and burst
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample this cycle
in_data  in  W_IN  signed low-rate sample
coef_we  in  1  coefficient write strobe
coef_addr  in  A_W  coefficient index = phase*TAPS + tap
coef_wdata  in  C_IN  signed coefficient
out_valid  out  1  out_data valid
out_phase  out  3  phase index of out_data (0..PHASES-1)
out_data  out  Y_OUT  signed interpolated sample

Behaviour:
- Reset (rstn=0, async): delay line d[0..TAPS-1]=0, all coefficients=0, state=IDLE, phase counter=0, out_valid=0, out_phase=0, out_data=0. in_ready=1 once out of reset.
- Accept rule: accept = in_valid && in_ready. On accept, the delay line shifts: d[0]<=in_data, d[k]<=d[k-1]. d[0] is the newest sample.
- FSM, state IDLE:
  - in_ready=1.
  - On accept: go to RUN with phase=0.
- FSM, state RUN:
  - Each cycle, compute y_p = sum over k of c[p*TAPS+k]*d[k] for the current phase p, and register it: out_data<=y_p, out_phase<=p, out_valid<=1.
  - Then phase increments.
  - in_ready=1 only when phase==PHASES-1. At that edge:
    - With accept: the delay line shifts and phase goes to 0; the burst continues with no bubble.
    - Without accept: go to IDLE.
- Output registering:
  - The last phase of a burst is computed from the pre-shift delay line; the new sample is first used by phase 0 of the next burst.
  - out_valid<=0 in any cycle where no phase is computed. out_data and out_phase hold their last values.
- Latency:
  - Sample accepted at edge t gives phase p visible after edge t+1+p.
  - Throughput: one input per PHASES cycles; continuous output when in_valid is held high.
- Arithmetic:
  - Products are full-precision signed, W_IN+C_IN bits.
  - The sum grows by clog2(TAPS) bits and is sign-extended to Y_OUT. Defaults give 14 bits, so no overflow is possible.
  - If the parameters make the sum wider than Y_OUT, keep the LSBs (two's-complement wrap). No saturation.
- Coefficient writes:
  - When coef_we=1 and coef_addr < PHASES*TAPS, the coefficient is written at the edge and used by any phase computed from the next cycle onward.
  - Writes to addr >= PHASES*TAPS are ignored.
  - A write and a computation of the same address in the same cycle use the old value.
  - Writes are legal in any state.
- Flush (synchronous, overrides in_valid):
  - d[]<=0, state<=IDLE, phase<=0, out_valid<=0.
  - Coefficients are kept.
  - in_ready is 0 during a flush cycle.
- Reset mid-burst: the burst is aborted immediately; no further out_valid until a new accept.
- in_data is ignored whenever in_ready=0. The source must hold in_valid/in_data until accepted.

Test Plan:
- Reset, then load c[p*4+0]=p-2 for p=0..5 with other taps 0; send x=5 -> out_valid for 6 cycles starting 2 edges after accept; out_phase 0..5; out_data -10,-5,0,5,10,15; then out_valid=0 and in_ready=1.
- Back-to-back: c[p*4+1]=1 for all p, others 0; in_valid held high with x=1,2,3 -> 18 consecutive valid outputs: 0 x6, then 1 x6, then 2 x6; in_ready high only on phase-5 cycles; no bubbles.
- Extremes: all 24 coefficients -16; send x=-64 four times, then observe the last burst -> every phase 4096. Repeat with x=63 -> -4032. Confirms signed handling and no wrap.
- Illegal address: write addr 24..31 with 7 after a valid load -> outputs unchanged from the prior run.
- Flush mid-burst: assert flush on phase 2 -> out_valid=0 next cycle; a following x=0 burst gives all zeros (delay line cleared); coefficients retained (a later x=5 reproduces scenario 1).
- Async reset during RUN phase 3 -> out_valid, out_data, out_phase = 0 immediately; after release, x=5 gives zeros (coefficients cleared).
